vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_coin_decode.sv | 13 +
 rtl/vend_ctrl.sv | 146 ++++++++++++++
 tb/tb_vend_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: FSM state codes, coin codes
// and the coin-to-credit-unit mapping.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_5C  = 2'd0;
  localparam logic [1:0] COIN_10C = 2'd1;
  localparam logic [1:0] COIN_20C = 2'd2;
  localparam logic [1:0] COIN_BAD = 2'd3;

  localparam int unsigned COIN_VAL_W = 3;

  // Credit units carried by a coin; an invalid coin is worth nothing.
  function automatic logic [COIN_VAL_W-1:0] coin_units(input logic [1:0] ct);
    case (ct)
      COIN_5C:  return 3'd1;
      COIN_10C: return 3'd2;
      COIN_20C: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder: unit value plus an invalid-coin flag.
module vend_coin_decode
  import vend_pkg::*;
(
  input  logic [1:0]            coin_type,
  output logic [COIN_VAL_W-1:0] coin_value,
  output logic                  coin_invalid
);

  assign coin_value   = coin_units(coin_type);
  assign coin_invalid = (coin_type == COIN_BAD);

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: collects coins, dispenses one product when the price is
// covered, then refunds remaining credit one unit per cycle.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 5,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic [CNT_W-1:0]    sold_count
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  if ((64'(MAX_CREDIT) >= (64'd1 << CREDIT_W)) || (PRICE < 1)) begin : g_param_check
    $error("vend_ctrl: MAX_CREDIT must fit in CREDIT_W bits and PRICE must be >= 1");
  end

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CNT_W-1:0]      sold_q, sold_d;
  logic                  disp_q, disp_d;
  logic                  chg_q, chg_d;
  logic                  rej_q, rej_d;
  logic                  busy_q, busy_d;

  logic [COIN_VAL_W-1:0] coin_value;
  logic                  coin_invalid;
  logic [SUM_W-1:0]      coin_sum;
  logic                  in_service;
  logic                  coin_rej_c;
  logic                  coin_acc_c;
  logic                  have_price_c;

  vend_coin_decode u_coin_decode (
    .coin_type    (coin_type),
    .coin_value   (coin_value),
    .coin_invalid (coin_invalid)
  );

  // Coin acceptance: no coins while serving, none alongside cancel, none past the cap.
  assign coin_sum     = SUM_W'(credit_q) + SUM_W'(coin_value);
  assign in_service   = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE);
  assign coin_rej_c   = coin_valid &&
                        (coin_invalid || in_service || cancel || (coin_sum > SUM_W'(MAX_CREDIT)));
  assign coin_acc_c   = coin_valid && !coin_rej_c;
  assign have_price_c = (credit_q >= CREDIT_W'(PRICE));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cancel outranks a pending dispense in COLLECT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (coin_acc_c) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (cancel && (credit_q != '0)) state_d = ST_CHANGE;
        else if (coin_acc_c)            state_d = ST_COLLECT;
        else if (have_price_c)          state_d = ST_DISPENSE;
      end
      ST_DISPENSE: begin
        state_d = (credit_q > CREDIT_W'(PRICE)) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (credit_q <= CREDIT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and pulse next values.
  always_comb begin
    credit_d = credit_q;
    sold_d   = sold_q;
    disp_d   = 1'b0;
    chg_d    = 1'b0;
    rej_d    = coin_rej_c;
    unique case (state_q)
      ST_DISPENSE: begin
        disp_d   = 1'b1;
        credit_d = credit_q - CREDIT_W'(PRICE);
        sold_d   = sold_q + CNT_W'(1);
      end
      ST_CHANGE: begin
        if (credit_q != '0) begin
          chg_d    = 1'b1;
          credit_d = credit_q - CREDIT_W'(1);
        end
      end
      default: begin
        if (coin_acc_c) credit_d = coin_sum[CREDIT_W-1:0];
      end
    endcase
    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q <= '0;
      sold_q   <= '0;
      disp_q   <= 1'b0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (ena) begin
      credit_q <= credit_d;
      sold_q   <= sold_d;
      disp_q   <= disp_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  // Held pulses are masked while stalled so each shows exactly once after ena returns.
  assign dispense     = disp_q && ena;
  assign change_pulse = chg_q && ena;
  assign coin_reject  = rej_q && ena;
  assign credit       = credit_q;
  assign state        = state_q;
  assign busy         = busy_q;
  assign sold_count   = sold_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Randomised and directed bench for vend_ctrl: two instances (default cap and
// MAX_CREDIT = 6) run side by side against a behavioural model.
module tb_vend_ctrl;

  localparam int PRICE = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       cancel = 1'b0;

  logic [7:0]  credit0, credit1;
  logic [1:0]  state0, state1;
  logic        dispense0, dispense1, change0, change1, reject0, reject1, busy0, busy1;
  logic [15:0] sold0, sold1;

  vend_ctrl u_dut0 (
    .clk(clk), .reset(reset), .ena(ena), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .credit(credit0), .state(state0), .dispense(dispense0),
    .change_pulse(change0), .coin_reject(reject0), .busy(busy0), .sold_count(sold0)
  );

  vend_ctrl #(.MAX_CREDIT(6)) u_dut1 (
    .clk(clk), .reset(reset), .ena(ena), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .credit(credit1), .state(state1), .dispense(dispense1),
    .change_pulse(change1), .coin_reject(reject1), .busy(busy1), .sold_count(sold1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 collecting, 2 vending, 3 refunding.
  int m_st[2], m_cr[2], m_sold[2];
  bit m_d[2], m_c[2], m_r[2];
  int maxc[2] = '{15, 6};

  function automatic int units(input int ct);
    if (ct == 0) return 1;
    if (ct == 1) return 2;
    if (ct == 2) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cr[i] = 0; m_sold[i] = 0;
      m_d[i] = 0; m_c[i] = 0; m_r[i] = 0;
    end
  endtask

  task automatic model_step(input bit cv, input int ct, input bit cn);
    for (int i = 0; i < 2; i++) begin
      int v;
      bit rej;
      v = units(ct);
      rej = cv && (ct == 3 || m_st[i] >= 2 || cn || (m_cr[i] + v > maxc[i]));
      m_r[i] = rej;
      m_d[i] = (m_st[i] == 2);
      m_c[i] = (m_st[i] == 3 && m_cr[i] > 0);
      if (m_st[i] == 2) begin
        m_cr[i] -= PRICE;
        m_sold[i]++;
        m_st[i] = (m_cr[i] > 0) ? 3 : 0;
      end else if (m_st[i] == 3) begin
        m_cr[i] -= 1;
        if (m_cr[i] == 0) m_st[i] = 0;
      end else if (cn && m_st[i] == 1 && m_cr[i] > 0) begin
        m_st[i] = 3;
      end else if (cv && !rej) begin
        m_cr[i] += v;
        m_st[i] = 1;
      end else if (m_st[i] == 1 && m_cr[i] >= PRICE) begin
        m_st[i] = 2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".credit0"}, 32'(credit0), 32'(m_cr[0]));
    check_val({tag, ".state0"}, 32'(state0), 32'(m_st[0]));
    check_val({tag, ".disp0"}, 32'(dispense0), 32'(m_d[0] && ena));
    check_val({tag, ".chg0"}, 32'(change0), 32'(m_c[0] && ena));
    check_val({tag, ".rej0"}, 32'(reject0), 32'(m_r[0] && ena));
    check_val({tag, ".busy0"}, 32'(busy0), 32'(m_st[0] >= 2));
    check_val({tag, ".sold0"}, 32'(sold0), 32'(m_sold[0] % 65536));
    check_val({tag, ".credit1"}, 32'(credit1), 32'(m_cr[1]));
    check_val({tag, ".state1"}, 32'(state1), 32'(m_st[1]));
    check_val({tag, ".disp1"}, 32'(dispense1), 32'(m_d[1] && ena));
    check_val({tag, ".chg1"}, 32'(change1), 32'(m_c[1] && ena));
    check_val({tag, ".rej1"}, 32'(reject1), 32'(m_r[1] && ena));
    check_val({tag, ".busy1"}, 32'(busy1), 32'(m_st[1] >= 2));
    check_val({tag, ".sold1"}, 32'(sold1), 32'(m_sold[1] % 65536));
  endtask

  task automatic cyc(input bit cv, input int ct, input bit cn, input bit en);
    @(negedge clk);
    coin_valid = cv; coin_type = 2'(ct); cancel = cn; ena = en;
    @(posedge clk);
    if (en) model_step(cv, ct, cn);
    #1 check_all("cyc");
  endtask

  // Async reset mid-cycle, held across an enabled edge with a coin offered.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ena = 1'b1; coin_valid = 1'b1; coin_type = 2'd2; cancel = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1 check_all("rst_hold");
    @(negedge clk);
    coin_valid = 1'b0; ena = 1'b0; reset = 1'b0;
  endtask

  task automatic wait_model(input int st, input int cr, input int budget);
    int n = 0;
    while (!(m_st[0] == st && (cr < 0 || m_cr[0] == cr)) && n < budget) begin
      cyc(0, 0, 0, 1);
      n++;
    end
    if (n >= budget) check_val("wait_timeout", 32'(n), 32'(0));
  endtask

  // Idle cycles on DUT0, tallying pulses and where they fell.
  task automatic idle_count(input int n, output int nd, output int nc, output int first_d,
                            output int first_c, output int last_c);
    nd = 0; nc = 0; first_d = -1; first_c = -1; last_c = -1;
    for (int k = 0; k < n; k++) begin
      cyc(0, 0, 0, 1);
      if (dispense0) begin nd++; if (first_d < 0) first_d = k; end
      if (change0) begin nc++; if (first_c < 0) first_c = k; last_c = k; end
    end
  endtask

  initial begin
    int nd, nc, fd, fc, lc, cb;
    do_reset();

    // Exact payment: 20c + 5c.
    cyc(1, 2, 0, 1); cyc(1, 0, 0, 1);
    idle_count(6, nd, nc, fd, fc, lc);
    check_val("s32.latency", 32'(fd), 32'(1));
    check_val("s32.ndisp", 32'(nd), 32'(1));
    check_val("s32.nchange", 32'(nc), 32'(0));
    check_val("s32.sold", 32'(sold0), 32'(1));

    // Over-payment: 20c + 20c, three change units.
    do_reset();
    cyc(1, 2, 0, 1); cyc(1, 2, 0, 1);
    idle_count(12, nd, nc, fd, fc, lc);
    check_val("s33.ndisp", 32'(nd), 32'(1));
    check_val("s33.nchange", 32'(nc), 32'(3));
    check_val("s33.consecutive", 32'(lc - fc), 32'(2));
    check_val("s33.credit", 32'(credit0), 32'(0));
    check_val("s33.state", 32'(state0), 32'(0));

    // Cancel refund.
    do_reset();
    cyc(1, 1, 0, 1); cyc(0, 0, 1, 1);
    idle_count(8, nd, nc, fd, fc, lc);
    check_val("s34.ndisp", 32'(nd), 32'(0));
    check_val("s34.nchange", 32'(nc), 32'(2));
    check_val("s34.credit", 32'(credit0), 32'(0));

    // Invalid coin, then a coin during refund.
    do_reset();
    cyc(1, 3, 0, 1);
    check_val("s35.rej_bad", 32'(reject0), 32'(1));
    check_val("s35.credit_bad", 32'(credit0), 32'(0));
    cyc(1, 2, 0, 1); cyc(1, 2, 0, 1);
    wait_model(3, -1, 10);
    cb = int'(credit0);
    cyc(1, 1, 0, 1);
    check_val("s35.rej_busy", 32'(reject0), 32'(1));
    check_val("s35.credit_busy", 32'(credit0), 32'(cb - 1));
    wait_model(0, -1, 20);

    // Overflow on the MAX_CREDIT = 6 instance.
    do_reset();
    cyc(1, 2, 0, 1); cyc(1, 2, 0, 1);
    check_val("s36.rej", 32'(reject1), 32'(1));
    check_val("s36.credit", 32'(credit1), 32'(4));
    cyc(0, 0, 1, 1);
    wait_model(0, -1, 20);

    // Reset during refund, then a stalled refund.
    do_reset();
    cyc(1, 2, 0, 1); cyc(1, 2, 0, 1);
    wait_model(3, 2, 20);
    do_reset();
    check_val("s37.rst_state", 32'(state0), 32'(0));
    check_val("s37.rst_credit", 32'(credit0), 32'(0));
    cyc(1, 2, 0, 1); cyc(1, 2, 0, 1);
    wait_model(3, -1, 10);
    cb = int'(credit0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0);
      check_val("s37.freeze_credit", 32'(credit0), 32'(cb));
      check_val("s37.freeze_state", 32'(state0), 32'(3));
    end
    idle_count(10, nd, nc, fd, fc, lc);
    check_val("s37.resume_pulses", 32'(nc), 32'(cb));
    check_val("s37.resume_credit", 32'(credit0), 32'(0));

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 9) < 4), int'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) < 17));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
